dbg_regfile_dump_ctrl: RTL and testbench

- Debug-mode sequencer for the MIPS register file's debug read port.
- On a start command it freezes the pipeline (stop_debug), blocks register-file writes (Debug_on), and walks the debug read address from 0 to NUM_REGS-1.
- Each 32-bit value is streamed MSB-first as bytes over a valid/ready interface to the UART TX path.
- Sits between the debug command decoder and the decode stage's debug ports.

---
 rtl/dbg_pkg.sv | 19 +
 rtl/dbg_word_serializer.sv | 53 +++++
 rtl/dbg_regfile_dump_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dbg_regfile_dump_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared types and constants for the register-file debug dump path.
// Frame-related items are only used when DBG_DUMP_FRAME_EN is defined.
package dbg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        DONE    = 3'd4,
        HEADER  = 3'd5,
        TRAILER = 3'd6
    } dbgState_t;

    localparam logic [7:0] DBG_SYNC_BYTE      = 8'hA5;
    localparam int         DBG_DATA_W         = 32;
    localparam int         DBG_BYTES_PER_WORD = DBG_DATA_W / 8;

endpackage

// File: rtl/dbg_word_serializer.sv
// Holds one register word and exposes it MSB-first a byte at a time,
// with a last-byte flag and a running XOR of every byte handed out.
module dbg_word_serializer
#(
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic              clearXor,
    input  logic [DATA_W-1:0] wordIn,
    output logic [7:0]        nextByte,
    output logic [7:0]        xorNext,
    output logic              lastByte
);
    localparam int BPW   = DATA_W / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_W-1:0] shiftReg;
    logic [DATA_W-1:0] shifted;
    logic [CNT_W-1:0]  byteIdx;
    logic [7:0]        xorAcc;

    assign shifted  = shiftReg << 8;
    assign nextByte = shifted[DATA_W-1 -: 8];
    assign lastByte = (byteIdx == CNT_W'(BPW - 1));
    // Includes the byte currently on offer, so the trailer can be formed on its accept.
    assign xorNext  = xorAcc ^ shiftReg[DATA_W-1 -: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shiftReg <= '0;
            byteIdx  <= '0;
            xorAcc   <= '0;
        end else begin
            if (load) begin
                shiftReg <= wordIn;
                byteIdx  <= '0;
            end else if (advance) begin
                shiftReg <= shifted;
                byteIdx  <= byteIdx + CNT_W'(1);
            end
            if (clearXor) begin
                xorAcc <= '0;
            end else if (advance) begin
                xorAcc <= xorNext;
            end
        end
    end

endmodule

// File: rtl/dbg_regfile_dump_ctrl.sv
// Freezes the pipeline and streams every register-file word MSB-first over valid/ready.
// DBG_DUMP_FRAME_EN adds a 0xA5 header byte and an XOR trailer byte around the payload.
//
// state   | meaning
// IDLE    | waiting for start, pipeline running
// HEADER  | offering the sync byte (framed build only)
// SETTLE  | waiting for the debug read port after an address change
// CAPTURE | latching dbg_read_data into the serializer
// SEND    | offering the word's bytes, MSB first
// TRAILER | offering the XOR of all payload bytes (framed build only)
// DONE    | one-cycle done pulse, release follows
module dbg_regfile_dump_ctrl
    import dbg_pkg::*;
#(
    parameter int NUM_REGS      = 32,
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              dbg_on,
    output logic              stop_pipe,
    output logic [ADDR_W-1:0] dbg_read_reg,
    input  logic [DATA_W-1:0] dbg_read_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST_REG    = ADDR_W'(NUM_REGS - 1);
    localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    dbgState_t  state;
    logic [3:0] settleCnt;
    logic       accept;
    logic       serLoad;
    logic       serAdvance;
    logic       serClear;
    logic       serLast;
    logic [7:0] serNext;
    logic [7:0] serXorNext;

    assign accept     = tx_valid && tx_ready;
    assign serLoad    = (state == CAPTURE);
    assign serAdvance = (state == SEND) && accept && !abort;
    assign serClear   = (state == IDLE) && start;

`ifndef DBG_DUMP_FRAME_EN
    logic unusedXor;
    assign unusedXor = ^serXorNext;
`endif

    dbg_word_serializer #(.DATA_W(DATA_W)) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .load     (serLoad),
        .advance  (serAdvance),
        .clearXor (serClear),
        .wordIn   (dbg_read_data),
        .nextByte (serNext),
        .xorNext  (serXorNext),
        .lastByte (serLast)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            settleCnt    <= '0;
            dbg_on       <= 1'b0;
            stop_pipe    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tx_valid     <= 1'b0;
            tx_data      <= '0;
            dbg_read_reg <= '0;
        end else if (abort && state != IDLE) begin
            // Partial word is dropped; tx_data keeps its last value but is no longer valid.
            state     <= IDLE;
            tx_valid  <= 1'b0;
            dbg_on    <= 1'b0;
            stop_pipe <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        dbg_read_reg <= '0;
                        dbg_on       <= 1'b1;
                        stop_pipe    <= 1'b1;
                        busy         <= 1'b1;
                        settleCnt    <= SETTLE_LOAD;
`ifdef DBG_DUMP_FRAME_EN
                        state        <= HEADER;
                        tx_valid     <= 1'b1;
                        tx_data      <= DBG_SYNC_BYTE;
`else
                        state        <= SETTLE;
`endif
                    end
                end
                HEADER: begin
                    if (accept) begin
                        tx_valid <= 1'b0;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settleCnt == 4'd0) begin
                        state <= CAPTURE;
                    end else begin
                        settleCnt <= settleCnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    tx_data  <= dbg_read_data[DATA_W-1 -: 8];
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (accept) begin
                        if (!serLast) begin
                            tx_data <= serNext;
                        end else if (dbg_read_reg == LAST_REG) begin
`ifdef DBG_DUMP_FRAME_EN
                            tx_data  <= serXorNext;
                            state    <= TRAILER;
`else
                            tx_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
`endif
                        end else begin
                            tx_valid     <= 1'b0;
                            dbg_read_reg <= dbg_read_reg + ADDR_W'(1);
                            settleCnt    <= SETTLE_LOAD;
                            state        <= SETTLE;
                        end
                    end
                end
                TRAILER: begin
                    if (accept) begin
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    dbg_on    <= 1'b0;
                    stop_pipe <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_regfile_dump_ctrl.sv
// Directed bench for dbg_regfile_dump_ctrl; expectations adapt when DBG_DUMP_FRAME_EN is defined.
module tb_dbg_regfile_dump_ctrl;

`ifdef DBG_DUMP_FRAME_EN
    localparam int FO          = 1;
    localparam int TOTAL_BYTES = 130;
    localparam int FIRST_VALID = 1;
    localparam int DONE_CYC    = 227;
`else
    localparam int FO          = 0;
    localparam int TOTAL_BYTES = 128;
    localparam int FIRST_VALID = 4;
    localparam int DONE_CYC    = 225;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        dbg_on;
    logic        stop_pipe;
    logic [4:0]  dbg_read_reg;
    logic [31:0] dbg_read_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [7:0]  rxQ [$];
    int          doneCnt;
    int          stallChanges;
    int          pipeDrops;
    int          pairMis;
    int          testsRun;
    int          testsFailed;
    bit          prevStall;
    logic [7:0]  prevData;

    always #5 clk = ~clk;

    assign dbg_read_data = regs[dbg_read_reg];

    dbg_regfile_dump_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .dbg_on        (dbg_on),
        .stop_pipe     (stop_pipe),
        .dbg_read_reg  (dbg_read_reg),
        .dbg_read_data (dbg_read_data),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .done          (done)
    );

    // Passive observer of the byte stream and handshake rules
    initial begin
        prevStall = 1'b0;
        prevData  = 8'h00;
        forever begin
            @(posedge clk);
            if (!rst) begin
                if (tx_valid && tx_ready) rxQ.push_back(tx_data);
                if (done) doneCnt++;
                if (busy && !stop_pipe) pipeDrops++;
                if (stop_pipe !== dbg_on) pairMis++;
                if (prevStall && tx_valid && tx_data !== prevData) stallChanges++;
                prevStall = tx_valid && !tx_ready && !abort;
                prevData  = tx_data;
            end else begin
                prevStall = 1'b0;
            end
        end
    end

    // pattern 0: reg[i] = 0x01010101*i ; pattern 1: bytes of reg[i] are 4i..4i+3
    task automatic loadRegs(input int pattern);
        for (int i = 0; i < 32; i++) begin
            if (pattern == 0) regs[i] = 32'h01010101 * i;
            else              regs[i] = 32'h00010203 + 32'h04040404 * i;
        end
    endtask

    function automatic logic [7:0] expByte(input int k, input int pattern);
        int p;
        p = k;
`ifdef DBG_DUMP_FRAME_EN
        if (k == 0) return 8'hA5;
        if (k == TOTAL_BYTES - 1) return 8'h00;
        p = k - 1;
`endif
        if (pattern == 0) return 8'(p / 4);
        return 8'(p);
    endfunction

    task automatic clearObs();
        rxQ.delete();
        doneCnt      = 0;
        stallChanges = 0;
        pipeDrops    = 0;
        pairMis      = 0;
    endtask

    task automatic runDump(input bit randReady, input int againReg,
                           output int firstValid, output int doneCyc);
        int cyc;
        bit againDone;
        firstValid = -1;
        doneCyc    = -1;
        againDone  = 1'b0;
        cyc        = 0;
        start      = 1'b1;
        tx_ready   = randReady ? ($urandom_range(0, 9) < 3) : 1'b1;
        while (doneCyc < 0 && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (firstValid < 0 && tx_valid) firstValid = cyc;
            if (done) doneCyc = cyc;
            if (againReg >= 0 && !againDone && int'(dbg_read_reg) == againReg) begin
                start     = 1'b1;
                againDone = 1'b1;
            end
            tx_ready = randReady ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++; if (tx_valid !== 1'b0) begin testsFailed++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("FAIL reset_busy got %b want 0", busy); end
        testsRun++; if (stop_pipe !== 1'b0 || dbg_on !== 1'b0) begin testsFailed++; $display("FAIL reset_freeze got stop=%b on=%b want 0 0", stop_pipe, dbg_on); end
        testsRun++; if (done !== 1'b0) begin testsFailed++; $display("FAIL reset_done got %b want 0", done); end
        testsRun++; if (tx_data !== 8'h00 || dbg_read_reg !== 5'd0) begin testsFailed++; $display("FAIL reset_data got data=%h reg=%0d want 00 0", tx_data, dbg_read_reg); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_dump();
        int fv, dc, bad;
        loadRegs(0);
        clearObs();
        runDump(1'b0, -1, fv, dc);
        bad = 0;
        for (int k = 0; k < rxQ.size() && k < TOTAL_BYTES; k++) if (rxQ[k] !== expByte(k, 0)) bad++;
        testsRun++; if (rxQ.size() != TOTAL_BYTES) begin testsFailed++; $display("FAIL full_count got %0d want %0d", rxQ.size(), TOTAL_BYTES); end
        testsRun++; if (bad != 0) begin testsFailed++; $display("FAIL full_bytes got %0d wrong bytes want 0", bad); end
        testsRun++; if (doneCnt != 1) begin testsFailed++; $display("FAIL full_done_count got %0d want 1", doneCnt); end
        testsRun++; if (fv != FIRST_VALID) begin testsFailed++; $display("FAIL full_first_valid got cycle %0d want %0d", fv, FIRST_VALID); end
        testsRun++; if (dc != DONE_CYC) begin testsFailed++; $display("FAIL full_done_cycle got %0d want %0d", dc, DONE_CYC); end
        testsRun++; if (pipeDrops != 0 || pairMis != 0) begin testsFailed++; $display("FAIL full_freeze got drops=%0d pairmis=%0d want 0 0", pipeDrops, pairMis); end
        testsRun++; if (busy !== 1'b0 || stop_pipe !== 1'b0 || dbg_on !== 1'b0) begin testsFailed++; $display("FAIL full_release got busy=%b stop=%b on=%b want 0 0 0", busy, stop_pipe, dbg_on); end
        testsRun++; if (dbg_read_reg !== 5'd31) begin testsFailed++; $display("FAIL full_last_reg got %0d want 31", dbg_read_reg); end
    endtask

    task automatic test_backpressure();
        int fv, dc, bad;
        loadRegs(1);
        clearObs();
        runDump(1'b1, -1, fv, dc);
        bad = 0;
        for (int k = 0; k < rxQ.size() && k < TOTAL_BYTES; k++) if (rxQ[k] !== expByte(k, 1)) bad++;
        testsRun++; if (dc < 0) begin testsFailed++; $display("FAIL bp_timeout got no done want done"); end
        testsRun++; if (rxQ.size() != TOTAL_BYTES) begin testsFailed++; $display("FAIL bp_count got %0d want %0d", rxQ.size(), TOTAL_BYTES); end
        testsRun++; if (bad != 0) begin testsFailed++; $display("FAIL bp_bytes got %0d wrong bytes want 0", bad); end
        testsRun++; if (stallChanges != 0) begin testsFailed++; $display("FAIL bp_stable got %0d changes want 0", stallChanges); end
        testsRun++; if (doneCnt != 1) begin testsFailed++; $display("FAIL bp_done_count got %0d want 1", doneCnt); end
    endtask

    task automatic test_abort();
        int n, fv, dc, bad;
        loadRegs(0);
        clearObs();
        start = 1'b1; tx_ready = 1'b1; n = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end while (rxQ.size() < 21 + FO && n < 1000);
        testsRun++; if (tx_valid !== 1'b1 || tx_data !== 8'h05 || dbg_read_reg !== 5'd5) begin testsFailed++; $display("FAIL abort_pending got v=%b d=%h reg=%0d want 1 05 5", tx_valid, tx_data, dbg_read_reg); end
        abort = 1'b1; tx_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        testsRun++; if (tx_valid !== 1'b0 || stop_pipe !== 1'b0 || busy !== 1'b0 || dbg_on !== 1'b0) begin testsFailed++; $display("FAIL abort_release got v=%b stop=%b busy=%b on=%b want 0 0 0 0", tx_valid, stop_pipe, busy, dbg_on); end
        repeat (5) @(posedge clk);
        #1;
        testsRun++; if (doneCnt != 0 || busy !== 1'b0) begin testsFailed++; $display("FAIL abort_no_done got done=%0d busy=%b want 0 0", doneCnt, busy); end
        clearObs();
        runDump(1'b0, -1, fv, dc);
        bad = 0;
        for (int k = 0; k < rxQ.size() && k < TOTAL_BYTES; k++) if (rxQ[k] !== expByte(k, 0)) bad++;
        testsRun++; if (rxQ.size() != TOTAL_BYTES || bad != 0) begin testsFailed++; $display("FAIL abort_restart got count=%0d wrong=%0d want %0d 0", rxQ.size(), bad, TOTAL_BYTES); end
    endtask

    task automatic test_start_ignored();
        int fv, dc, bad;
        loadRegs(1);
        clearObs();
        runDump(1'b0, 10, fv, dc);
        repeat (4) @(posedge clk);
        #1;
        bad = 0;
        for (int k = 0; k < rxQ.size() && k < TOTAL_BYTES; k++) if (rxQ[k] !== expByte(k, 1)) bad++;
        testsRun++; if (rxQ.size() != TOTAL_BYTES || bad != 0) begin testsFailed++; $display("FAIL restart_bytes got count=%0d wrong=%0d want %0d 0", rxQ.size(), bad, TOTAL_BYTES); end
        testsRun++; if (doneCnt != 1 || busy !== 1'b0) begin testsFailed++; $display("FAIL restart_done got done=%0d busy=%b want 1 0", doneCnt, busy); end
    endtask

    task automatic test_async_reset();
        int n;
        loadRegs(0);
        clearObs();
        start = 1'b1; tx_ready = 1'b1; n = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end while (dbg_read_reg != 5'd3 && n < 1000);
        tx_ready = 1'b0;
        n = 0;
        while (!tx_valid && n < 50) begin @(posedge clk); #1; n++; end
        testsRun++; if (tx_valid !== 1'b1 || tx_data !== 8'h03) begin testsFailed++; $display("FAIL arst_pre got v=%b d=%h want 1 03", tx_valid, tx_data); end
        #3 rst = 1'b1;
        #1;
        testsRun++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin testsFailed++; $display("FAIL arst_now got v=%b d=%h busy=%b done=%b want 0 00 0 0", tx_valid, tx_data, busy, done); end
        testsRun++; if (stop_pipe !== 1'b0 || dbg_on !== 1'b0 || dbg_read_reg !== 5'd0) begin testsFailed++; $display("FAIL arst_freeze got stop=%b on=%b reg=%0d want 0 0 0", stop_pipe, dbg_on, dbg_read_reg); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        testsRun++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("FAIL arst_idle got v=%b busy=%b want 0 0", tx_valid, busy); end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        clearObs();
        loadRegs(0);
        test_reset();
        test_full_dump();
        test_backpressure();
        test_abort();
        test_start_ignored();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
